// File: rtl/neo_frame_builder.sv
// ============================================================================
// Module      : neo_frame_builder
// Description : Double-buffered GRBW frame builder for a NeoPixel string driver,
//               with commit coalescing and minimum frame-period lockout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module neo_frame_builder #(
    parameter int NUM_LEDS     = 30,
    parameter int WORD_W       = 32,
    parameter int IDX_W        = 5,
    parameter int FRAME_CYCLES = 116010
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [WORD_W-1:0]          wr_grbw,
    input  logic                       commit,
    output logic [NUM_LEDS*WORD_W-1:0] colors,
    output logic                       send,
    output logic                       busy,
    output logic [15:0]                frame_count,
    output logic                       err_idx
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SWAP    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    localparam logic [16:0] LOCK_LAST = 17'(FRAME_CYCLES - 2);
    localparam logic [16:0] LOCK_MAX  = '1;

    state_t                            state_q, state_d;
    logic [16:0]                       lock_cnt_q, lock_cnt_d;
    logic [NUM_LEDS-1:0][WORD_W-1:0]   back_q, back_d;
    logic [NUM_LEDS-1:0][WORD_W-1:0]   front_q, front_d;
    logic                              commit_pend_q, commit_pend_d;
    logic                              send_q, send_d;
    logic                              wr_ready_q, wr_ready_d;
    logic                              err_idx_q, err_idx_d;
    logic [15:0]                       frame_count_q, frame_count_d;
    logic                              wr_fire;

    assign wr_fire = wr_valid && wr_ready_q;

    always_comb begin
        state_d       = state_q;
        lock_cnt_d    = lock_cnt_q;
        back_d        = back_q;
        front_d       = front_q;
        commit_pend_d = commit_pend_q | commit;
        send_d        = 1'b0;
        err_idx_d     = err_idx_q;
        frame_count_d = frame_count_q;

        // Out-of-range indices still complete the handshake but only raise the flag
        if (wr_fire) begin
            if (int'(wr_idx) < NUM_LEDS) begin
                back_d[wr_idx] = wr_grbw;
            end else begin
                err_idx_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (commit_pend_q || commit) begin
                    state_d = ST_SWAP;
                end
            end
            ST_SWAP: begin
                front_d       = back_q;
                commit_pend_d = commit;
                send_d        = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
                lock_cnt_d    = '0;
                state_d       = ST_LOCKOUT;
            end
            ST_LOCKOUT: begin
                if (lock_cnt_q == LOCK_LAST) begin
                    state_d = ST_IDLE;
                end
                if (lock_cnt_q != LOCK_MAX) begin
                    lock_cnt_d = lock_cnt_q + 17'd1;
                end
            end
            default: begin
                lock_cnt_d = '0;
                state_d    = ST_LOCKOUT;
            end
        endcase

        // Registered ready tracks the state we are about to enter
        wr_ready_d = (state_d != ST_SWAP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_LOCKOUT;
            lock_cnt_q    <= '0;
            back_q        <= '0;
            front_q       <= '0;
            commit_pend_q <= 1'b0;
            send_q        <= 1'b0;
            wr_ready_q    <= 1'b0;
            err_idx_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            lock_cnt_q    <= lock_cnt_d;
            back_q        <= back_d;
            front_q       <= front_d;
            commit_pend_q <= commit_pend_d;
            send_q        <= send_d;
            wr_ready_q    <= wr_ready_d;
            err_idx_q     <= err_idx_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign colors      = front_q;
    assign send        = send_q;
    assign wr_ready    = wr_ready_q;
    assign err_idx     = err_idx_q;
    assign frame_count = frame_count_q;
    assign busy        = commit_pend_q || (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_neo_frame_builder.sv
// ============================================================================
// Module      : tb_neo_frame_builder
// Description : Directed self-checking bench for neo_frame_builder (short frame period).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_neo_frame_builder;

    localparam int F = 64;
    localparam int N = 30;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [4:0]    wr_idx;
    logic [31:0]   wr_grbw;
    logic          commit;
    logic [959:0]  colors;
    logic          send;
    logic          busy;
    logic [15:0]   frame_count;
    logic          err_idx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int send_total = 0;
    logic [31:0] exp_front [N];
    logic [31:0] exp_back  [N];

    neo_frame_builder #(
        .NUM_LEDS     (N),
        .WORD_W       (32),
        .IDX_W        (5),
        .FRAME_CYCLES (F)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_idx      (wr_idx),
        .wr_grbw     (wr_grbw),
        .commit      (commit),
        .colors      (colors),
        .send        (send),
        .busy        (busy),
        .frame_count (frame_count),
        .err_idx     (err_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (send === 1'b1) send_total = send_total + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_colors(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_w%0d", tag, i), colors[i*32 +: 32], exp_front[i]);
        end
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] data);
        int n;
        n = 0;
        wr_idx   = idx;
        wr_grbw  = data;
        wr_valid = 1'b1;
        while (wr_ready !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("wr_ready_wait", {31'b0, wr_ready}, 32'd1);
        tick();
        wr_valid = 1'b0;
        if (int'(idx) < N) exp_back[idx] = data;
    endtask

    task automatic commit_pulse();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic wait_send(input string tag, output int t);
        int n;
        n = 0;
        while (send !== 1'b1 && n < F + 20) begin
            tick();
            n++;
        end
        chk({tag, "_send"}, {31'b0, send}, 32'd1);
        t = cyc;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2 * F) begin
            tick();
            n++;
        end
        chk("wait_idle", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int t_prev;
        int t;
        int s0;

        rst      = 1'b1;
        wr_valid = 1'b0;
        commit   = 1'b0;
        wr_idx   = '0;
        wr_grbw  = '0;
        for (int i = 0; i < N; i++) begin
            exp_front[i] = '0;
            exp_back[i]  = '0;
        end

        // Reset state and initial lockout length
        tick();
        tick();
        chk("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
        chk("rst_send", {31'b0, send}, 32'd0);
        chk("rst_count", {16'b0, frame_count}, 32'd0);
        chk("rst_err", {31'b0, err_idx}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        check_colors("rst");
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 2 * F) begin
            tick();
            n++;
        end
        chk("lockout_len", n, F - 1);
        chk("ready_after_rst", {31'b0, wr_ready}, 32'd1);
        chk("no_early_send", send_total, 32'd0);

        // Basic frame: send exactly two cycles after the commit
        wr(5'd0, 32'hFF000000);
        wr(5'd29, 32'h000000FF);
        commit = 1'b1;
        for (int i = 0; i < N; i++) exp_front[i] = exp_back[i];
        tick();
        commit = 1'b0;
        chk("swap_send", {31'b0, send}, 32'd0);
        chk("swap_ready", {31'b0, wr_ready}, 32'd0);
        chk("swap_busy", {31'b0, busy}, 32'd1);
        tick();
        chk("basic_send", {31'b0, send}, 32'd1);
        check_colors("basic");
        chk("basic_count", {16'b0, frame_count}, 32'd1);
        t_prev = cyc;
        tick();
        chk("basic_pulse_end", {31'b0, send}, 32'd0);

        // Coalesce three commits issued during lockout
        wr(5'd5, 32'h12345678);
        s0 = send_total;
        commit_pulse();
        tick();
        commit_pulse();
        commit_pulse();
        for (int i = 0; i < N; i++) exp_front[i] = exp_back[i];
        wait_send("coalesce", t);
        chk("coalesce_spacing", t - t_prev, F + 1);
        chk("coalesce_count", {16'b0, frame_count}, 32'd2);
        check_colors("coalesce");
        t_prev = t;
        tick();
        wait_idle();
        repeat (4) tick();
        chk("coalesce_one_send", send_total - s0, 32'd1);

        // Out-of-range index
        wr(5'd30, 32'hDEADBEEF);
        chk("badidx_err", {31'b0, err_idx}, 32'd1);
        commit_pulse();
        for (int i = 0; i < N; i++) exp_front[i] = exp_back[i];
        wait_send("badidx", t);
        chk("badidx_count", {16'b0, frame_count}, 32'd3);
        check_colors("badidx");
        for (int i = 10; i < 20; i++) wr(5'(i), 32'(i) * 32'h01010101);
        chk("badidx_sticky", {31'b0, err_idx}, 32'd1);

        // Write stalled through the SWAP cycle
        wait_idle();
        commit = 1'b1;
        for (int i = 0; i < N; i++) exp_front[i] = exp_back[i];
        tick();
        commit = 1'b0;
        chk("stall_ready_swap", {31'b0, wr_ready}, 32'd0);
        wr_valid = 1'b1;
        wr_idx   = 5'd7;
        wr_grbw  = 32'hA5A5A5A5;
        tick();
        chk("stall_send", {31'b0, send}, 32'd1);
        chk("stall_ready_after", {31'b0, wr_ready}, 32'd1);
        check_colors("stall");
        tick();
        wr_valid = 1'b0;
        exp_back[7] = 32'hA5A5A5A5;
        chk("stall_pulse_end", {31'b0, send}, 32'd0);
        chk("stall_still_old", colors[7*32 +: 32], 32'h00000000);
        commit_pulse();
        for (int i = 0; i < N; i++) exp_front[i] = exp_back[i];
        wait_send("stall_next", t);
        chk("stall_next_count", {16'b0, frame_count}, 32'd5);
        chk("stall_word7", colors[7*32 +: 32], 32'hA5A5A5A5);
        check_colors("stall_next");

        // Reset mid-lockout with a commit pending
        tick();
        commit_pulse();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        s0 = send_total;
        for (int i = 0; i < N; i++) begin
            exp_front[i] = '0;
            exp_back[i]  = '0;
        end
        chk("rst2_count", {16'b0, frame_count}, 32'd0);
        chk("rst2_err", {31'b0, err_idx}, 32'd0);
        chk("rst2_busy", {31'b0, busy}, 32'd1);
        check_colors("rst2");
        repeat (F + 10) tick();
        chk("rst2_no_send", send_total - s0, 32'd0);
        chk("rst2_idle", {31'b0, busy}, 32'd0);
        chk("rst2_count_end", {16'b0, frame_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
